// File: rtl/reset_sequencer.sv
// reset_sequencer: system reset controller downstream of the hardware watchdog.
// Merges the power-on/external reset, watchdog expiry and a keyed software
// request into one stretched, synchronously released active-low system reset.
// Reset-cause flags and the watchdog-expiry counter are reset only by rst, so
// they survive sys_rst_n and can be read by firmware after reboot.
//
// Parameters:
//   STRETCH_US   sys_rst_n low time in tick_1us periods (>= 1)
//   SYNC_STAGES  extra clk cycles spent in StSync before release (>= 1)
// Ports:
//   clk        system clock
//   rst        asynchronous active-high power-on/external reset
//   tick_1us   1-cycle 1 MHz strobe
//   wdt_reset  1-cycle watchdog expiry pulse
//   sw_req     bus write strobe for the status slot
//   sw_data    bus write data; [31:24]==8'hA5 key, [1] clear, [0] soft reset
//   status     {16'h0, wdt_count, 3'b0, sys_rst_n, 1'b0, cause}
//   sys_rst_n  registered active-low system reset
module reset_sequencer #(
  parameter int unsigned STRETCH_US  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1us,
  input  logic        wdt_reset,
  input  logic        sw_req,
  input  logic [31:0] sw_data,
  output logic [31:0] status,
  output logic        sys_rst_n
);

  localparam int unsigned CntW  = $clog2(STRETCH_US + 1);
  localparam int unsigned SyncW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

  localparam logic [CntW-1:0]  CntInit  = CntW'(STRETCH_US);
  localparam logic [SyncW-1:0] SyncLast = SyncW'(SYNC_STAGES - 1);

  localparam logic [2:0] CausePor = 3'b001;

  typedef enum logic [1:0] {StHold, StSync, StRun} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SyncW-1:0] sync_cnt_q, sync_cnt_d;
  logic [2:0]       cause_q, cause_d;
  logic [7:0]       wdt_count_q, wdt_count_d;
  logic             sys_rst_n_q, sys_rst_n_d;

  logic wr_valid;
  logic wr_clear;
  logic wr_soft;

  // Payload bits between the key and the command bits carry no meaning.
  logic unused_data;
  assign unused_data = ^sw_data[23:2];

  assign wr_valid = sw_req && (sw_data[31:24] == 8'hA5);
  assign wr_clear = wr_valid && sw_data[1];
  assign wr_soft  = wr_valid && sw_data[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sync_cnt_d  = sync_cnt_q;
    cause_d     = cause_q;
    wdt_count_d = wdt_count_q;
    sys_rst_n_d = sys_rst_n_q;

    unique case (state_q)
      StHold: begin
        if (tick_1us) begin
          if (cnt_q == CntW'(1)) begin
            state_d    = StSync;
            sync_cnt_d = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end

      StSync: begin
        if (sync_cnt_q == SyncLast) begin
          state_d     = StRun;
          sys_rst_n_d = 1'b1;
        end else begin
          sync_cnt_d = sync_cnt_q + SyncW'(1);
        end
      end

      StRun: begin
        // Clear is applied first so a same-cycle reset event builds on zeroed state.
        if (wr_clear) begin
          cause_d     = '0;
          wdt_count_d = '0;
        end
        if (wdt_reset || wr_soft) begin
          state_d     = StHold;
          cnt_d       = CntInit;
          sys_rst_n_d = 1'b0;
          cause_d     = {wr_soft, wdt_reset, 1'b0};
          if (wdt_reset && (wdt_count_d != 8'hFF)) begin
            wdt_count_d = wdt_count_d + 8'd1;
          end
        end
      end

      default: begin
        state_d     = StHold;
        cnt_d       = CntInit;
        sys_rst_n_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHold;
      cnt_q       <= CntInit;
      sync_cnt_q  <= '0;
      cause_q     <= CausePor;
      wdt_count_q <= '0;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      cause_q     <= cause_d;
      wdt_count_q <= wdt_count_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign status    = {16'h0, wdt_count_q, 3'b000, sys_rst_n_q, 1'b0, cause_q};

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer. Expected values are
// pushed to a scoreboard queue when stimulus is applied and popped when the
// corresponding DUT observation is taken.
module tb_reset_sequencer;

  localparam int unsigned StretchUs  = 16;
  localparam int unsigned SyncStages = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1us = 1'b0;
  logic        wdt_reset = 1'b0;
  logic        sw_req = 1'b0;
  logic [31:0] sw_data = '0;
  logic [31:0] status;
  logic        sys_rst_n;

  int          tick_period = 25;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];

  reset_sequencer #(
    .STRETCH_US (StretchUs),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1us (tick_1us),
    .wdt_reset(wdt_reset),
    .sw_req   (sw_req),
    .sw_data  (sw_data),
    .status   (status),
    .sys_rst_n(sys_rst_n)
  );

  always #5 clk = ~clk;

  // One-cycle tick every tick_period clocks.
  initial begin
    forever begin
      repeat (tick_period - 1) @(negedge clk);
      tick_1us = 1'b1;
      @(negedge clk);
      tick_1us = 1'b0;
    end
  end

  task automatic expect_val(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: got %h, scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Drive one cycle of inputs, seen by exactly one rising edge.
  task automatic pulse(input logic wdt, input logic req, input logic [31:0] data);
    @(negedge clk);
    wdt_reset = wdt;
    sw_req    = req;
    sw_data   = data;
    @(negedge clk);
    wdt_reset = 1'b0;
    sw_req    = 1'b0;
    sw_data   = '0;
  endtask

  // Measure the low phase starting at the edge after the reset event: ticks
  // seen while low, then clocks from the last tick to release. Optionally
  // inject one input pulse at loop cycle inj_at (during the stretch).
  task automatic wait_release(input string tag, input int inj_at, input logic inj_wdt,
                              input logic inj_req, input logic [31:0] inj_data);
    int ticks;
    int since;
    bit done;
    ticks = 0;
    since = 0;
    done  = 1'b0;
    expect_val(StretchUs);
    expect_val(SyncStages);
    for (int i = 0; i < 5000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sys_rst_n) begin
        done = 1'b1;
      end else if (tick_1us) begin
        ticks++;
        since = 0;
      end else begin
        since++;
      end
      if (i == inj_at) begin
        wdt_reset = inj_wdt;
        sw_req    = inj_req;
        sw_data   = inj_data;
      end else if (i == inj_at + 1) begin
        wdt_reset = 1'b0;
        sw_req    = 1'b0;
        sw_data   = '0;
      end
    end
    if (!done) begin
      ticks = -1;
      since = -2;
    end
    check({tag, " ticks"}, 32'(ticks));
    check({tag, " sync"}, 32'(since + 1));
  endtask

  initial begin
    // Power-on reset state.
    repeat (3) @(negedge clk);
    expect_val(32'h0000_0001);
    check("por status", status);
    expect_val(32'h0);
    check("por sys_rst_n", 32'(sys_rst_n));

    rst = 1'b0;
    wait_release("por release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0011);
    check("por run status", status);

    // Watchdog expiry.
    pulse(1'b1, 1'b0, '0);
    expect_val(32'h0);
    check("wdt sys_rst_n", 32'(sys_rst_n));
    wait_release("wdt release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0112);
    check("wdt status", status);

    // Keyed soft reset, then an unkeyed write.
    pulse(1'b0, 1'b1, 32'hA500_0001);
    expect_val(32'h0);
    check("soft sys_rst_n", 32'(sys_rst_n));
    wait_release("soft release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0114);
    check("soft status", status);

    pulse(1'b0, 1'b1, 32'h1200_0001);
    repeat (10) @(negedge clk);
    expect_val(32'h0000_0114);
    check("bad key status", status);

    // Watchdog and soft reset in the same cycle.
    pulse(1'b1, 1'b1, 32'hA500_0001);
    wait_release("both release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0216);
    check("both status", status);

    // Events during HOLD are ignored and do not restart the stretch.
    pulse(1'b1, 1'b0, '0);
    wait_release("hold wdt release", 60, 1'b1, 1'b0, '0);
    expect_val(32'h0000_0312);
    check("hold wdt status", status);

    pulse(1'b0, 1'b1, 32'hA500_0001);
    wait_release("hold write release", 60, 1'b0, 1'b1, 32'hA500_0003);
    expect_val(32'h0000_0314);
    check("hold write status", status);

    // Clear-only write in RUN.
    pulse(1'b0, 1'b1, 32'hA500_0002);
    expect_val(32'h0000_0010);
    check("clear status", status);
    repeat (30) @(negedge clk);
    expect_val(32'h1);
    check("clear sys_rst_n", 32'(sys_rst_n));

    // Clear + soft reset, then clear + watchdog.
    pulse(1'b1, 1'b0, '0);
    wait_release("pre clr release", -1, 1'b0, 1'b0, '0);
    pulse(1'b0, 1'b1, 32'hA500_0003);
    wait_release("clr soft release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0014);
    check("clr soft status", status);

    pulse(1'b1, 1'b1, 32'hA500_0002);
    wait_release("clr wdt release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0112);
    check("clr wdt status", status);

    // Saturation: 257 expiries from zero, faster tick to keep runtime short.
    tick_period = 2;
    pulse(1'b0, 1'b1, 32'hA500_0002);
    for (int n = 1; n <= 257; n++) begin
      pulse(1'b1, 1'b0, '0);
      wait_release("sat release", -1, 1'b0, 1'b0, '0);
      if (n == 254) begin
        expect_val(32'h0000_FE12);
        check("count 254", status);
      end else if (n == 255) begin
        expect_val(32'h0000_FF12);
        check("count 255", status);
      end
    end
    expect_val(32'h0000_FF12);
    check("count saturated", status);
    tick_period = 25;

    // rst mid-HOLD: full re-init and full-length stretch.
    pulse(1'b1, 1'b0, '0);
    repeat (100) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_val(32'h0000_0001);
    check("mid hold rst status", status);
    @(negedge clk);
    rst = 1'b0;
    wait_release("mid hold rst release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0011);
    check("mid hold rst run", status);

    // Asynchronous assertion from RUN, away from any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_val(32'h0);
    check("async sys_rst_n", 32'(sys_rst_n));
    @(negedge clk);
    rst = 1'b0;
    wait_release("async release", -1, 1'b0, 1'b0, '0);
    expect_val(32'h0000_0011);
    check("async run status", status);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
